spi_bus_arbiter: RTL and testbench
==================================

# spi_bus_arbiter

Shares the board's single SPI bus (SCK/MOSI/MISO) between the amplifier-gain, ADC-capture and DAC-output controllers. It grants the bus to one requester at a time using round-robin order, and inserts an idle gap between owners. It multiplexes the granted requester's SCK/MOSI onto the pins and routes MISO back only to the owner. It sits between the acquisition sequencer's peripheral drivers and the top-level SPI pins.

## Interface
Parameters:
- GAP_CYCLES, 2: idle bus cycles between one release and the next grant (1..15).
- TIMEOUT_CYCLES, 4096: maximum cycles one grant may last; active only with the timeout feature (1..65535).

Ports:
- CLK50MHZ  input  1  system clock, 50 MHz, all logic on its rising edge.
- RST  input  1  synchronous, active-low reset.
- req  input  3  bus requests; bit0 amp, bit1 adc, bit2 dac.
- gnt  output  3  one-hot registered grant, same bit order.
- req_sck  input  3  per-requester SCK.
- req_mosi  input  3  per-requester MOSI.
- req_miso  output  3  gated MISO; only the granted bit carries spi_miso, others 0.
- spi_sck  output  1  SCK pin.
- spi_mosi  output  1  MOSI pin.
- spi_miso  input  1  MISO pin.
- busy  output  1  high in GRANT or GAP.
- owner  output  2  index of the current or last owner; 3 = none since reset.
- timeout_err  output  1  one-cycle pulse when a grant is revoked.

## Operation
- The state machine has three states: IDLE, GRANT and GAP.
- IDLE, with any eligible req high:
  - Choose the first req at or after the round-robin pointer, in order amp→adc→dac→amp.
  - Set that gnt bit, latch owner, go to GRANT.
  - Set pointer = owner+1 mod 3.
- GRANT:
  - Hold gnt while the owner's req stays high.
  - Other requests are ignored.
  - When the owner's req drops, clear gnt and go to GAP.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - A req arriving during GAP waits.
- Multiplexing:
  - spi_sck and spi_mosi = the granted requester's lines; 0 when no gnt bit is set.
  - req_miso is masked the same way.
  - This path is combinational from the gnt register.
- Protocol:
  - A requester drives SCK/MOSI only while it sees its gnt.
  - It drops req only after its final SCK edge and chip-select release.
- Reset values:
  - gnt=0, req_miso=0, spi_sck=0, spi_mosi=0, busy=0, owner=3, timeout_err=0.
  - pointer=amp, state=IDLE.
- Reset during GRANT: all outputs reach their reset values at the reset edge with no gap. The first grant after reset follows pointer=amp.
- Simultaneous requests are resolved by the round-robin pointer only. Arrival order is not tracked.
- A req that pulses high and low during GAP or GRANT of another owner is lost; requests are level, not latched.

## Timing
- Grant latency: a req sampled high at edge n in IDLE gives gnt high after edge n. This is one cycle from req to gnt.
- Release: the owner's req is sampled low at edge m. gnt is low after edge m. The next gnt is high no earlier than after edge m+GAP_CYCLES+1.
- Minimum bus dead time between owners: GAP_CYCLES+1 cycles with spi_sck=0.
- busy rises with gnt and falls when GAP exits.

## Configuration
SPI_ARB_TIMEOUT_EN:
- Defined:
  - A 16-bit counter runs in GRANT.
  - On reaching TIMEOUT_CYCLES with req still high, gnt clears, timeout_err pulses for one cycle, and the state goes to GAP.
  - The revoked requester is masked from arbitration until its req is seen low.
- Undefined: no counter, timeout_err tied 0, grants are unbounded.

## Structure
- Shared package spi_arb_pkg holds:
  - Requester indices REQ_AMP=0, REQ_ADC=1, REQ_DAC=2, NUM_REQ=3.
  - State encodings ST_IDLE, ST_GRANT, ST_GAP.
  - OWNER_NONE=3.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: 3-bit req, masked, and 2-bit pointer.
  - Outputs: 1-bit valid and 2-bit index.

## Test plan
- Reset, then only req=3'b010 held for 20 cycles → gnt=3'b010 one cycle after req, owner=1, spi_sck follows req_sck[1], req_miso[0]=req_miso[2]=0.
- req=3'b111 held continuously, each owner drops its req after 10 cycles then re-raises it → grant order amp, adc, dac, amp; exactly GAP_CYCLES+1 idle cycles between grants.
- adc owns the bus and amp raises req mid-grant → amp is not granted until adc releases plus the gap; spi_mosi never shows req_mosi[0] during the adc grant.
- RST=0 asserted for one cycle mid-grant with req=3'b100 held → next cycle gnt=0, spi_sck=0, owner=3, busy=0. After reset release, gnt=3'b100 one cycle later.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, dac holds req for 40 cycles → gnt drops after 16 cycles, one timeout_err pulse, dac not regranted until its req goes low and high again.
- Without SPI_ARB_TIMEOUT_EN, the same stimulus → dac holds the bus for all 40 cycles and timeout_err stays 0.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// -----------------------------------------------------------------------------
// spi_arb_pkg
//   Shared definitions for the SPI bus arbiter: requester indices, FSM state
//   encodings, the "no owner yet" marker and small index helpers used by both
//   the top level and the round-robin picker.
// -----------------------------------------------------------------------------
package spi_arb_pkg;

    // Requester indices; bit order of every 3-bit request/grant vector.
    localparam int         NUM_REQ    = 3;
    localparam logic [1:0] REQ_AMP    = 2'd0;
    localparam logic [1:0] REQ_ADC    = 2'd1;
    localparam logic [1:0] REQ_DAC    = 2'd2;
    localparam logic [1:0] OWNER_NONE = 2'd3;

    // Arbiter FSM state encodings (plain constants for legacy tools).
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef logic [NUM_REQ-1:0] req_vec_t;

    // Next round-robin position after idx (amp -> adc -> dac -> amp).
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            REQ_AMP: nxt = REQ_ADC;
            REQ_ADC: nxt = REQ_DAC;
            REQ_DAC: nxt = REQ_AMP;
            default: nxt = REQ_AMP;
        endcase
        return nxt;
    endfunction

    // One-hot vector for a requester index; OWNER_NONE maps to all zeros.
    function automatic req_vec_t idx_onehot(input logic [1:0] idx);
        req_vec_t vec;
        case (idx)
            REQ_AMP: vec = 3'b001;
            REQ_ADC: vec = 3'b010;
            REQ_DAC: vec = 3'b100;
            default: vec = 3'b000;
        endcase
        return vec;
    endfunction

    // Select one bit of a request vector by index; OWNER_NONE reads as 0.
    function automatic logic idx_bit(input req_vec_t vec, input logic [1:0] idx);
        logic b;
        case (idx)
            REQ_AMP: b = vec[0];
            REQ_ADC: b = vec[1];
            REQ_DAC: b = vec[2];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Returns the first eligible requester at
//   or after the pointer, scanning amp -> adc -> dac -> amp.
//   Ports:
//     req     in  3  raw request levels
//     masked  in  3  requesters excluded from this pick
//     pointer in  2  index where the scan starts (values above dac start at amp)
//     valid   out 1  at least one eligible requester
//     index   out 2  chosen requester, OWNER_NONE when valid is low
// -----------------------------------------------------------------------------
module rr_pick
    import spi_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [2:0] masked,
    input  logic [1:0] pointer,
    output logic       valid,
    output logic [1:0] index
);

    req_vec_t elig_s;

    assign elig_s = req & ~masked;
    assign valid  = |elig_s;

    // Rotating priority scan starting from the pointer position.
    always_comb begin
        index = OWNER_NONE;
        case (pointer)
            REQ_ADC: begin
                if (elig_s[1])      index = REQ_ADC;
                else if (elig_s[2]) index = REQ_DAC;
                else if (elig_s[0]) index = REQ_AMP;
                else                index = OWNER_NONE;
            end
            REQ_DAC: begin
                if (elig_s[2])      index = REQ_DAC;
                else if (elig_s[0]) index = REQ_AMP;
                else if (elig_s[1]) index = REQ_ADC;
                else                index = OWNER_NONE;
            end
            default: begin
                if (elig_s[0])      index = REQ_AMP;
                else if (elig_s[1]) index = REQ_ADC;
                else if (elig_s[2]) index = REQ_DAC;
                else                index = OWNER_NONE;
            end
        endcase
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spi_bus_arbiter
//   Shares one SPI bus between the amp-gain (bit0), ADC-capture (bit1) and
//   DAC-output (bit2) controllers. One owner at a time, round-robin order,
//   an idle gap of GAP_CYCLES between owners, and SCK/MOSI/MISO steered to and
//   from the owner only.
//
//   Parameters:
//     GAP_CYCLES     idle cycles between a release and the next grant (1..15)
//     TIMEOUT_CYCLES longest allowed grant when the timeout is built (1..65535)
//
//   Optional feature: define SPI_ARB_TIMEOUT_EN to bound every grant to
//   TIMEOUT_CYCLES cycles; a revoked requester is locked out until it lowers
//   its req. Without the macro grants are unbounded and timeout_err is 0.
//
//   Ports:
//     CLK50MHZ    in  1  system clock, rising edge
//     RST         in  1  synchronous active-low reset
//     req         in  3  request levels
//     gnt         out 3  registered one-hot grant
//     req_sck     in  3  per-requester SCK
//     req_mosi    in  3  per-requester MOSI
//     req_miso    out 3  spi_miso routed to the granted requester only
//     spi_sck     out 1  SCK pin
//     spi_mosi    out 1  MOSI pin
//     spi_miso    in  1  MISO pin
//     busy        out 1  high in GRANT or GAP
//     owner       out 2  current/last owner, 3 until the first grant
//     timeout_err out 1  one-cycle pulse on a revoked grant
// -----------------------------------------------------------------------------
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       CLK50MHZ,
    input  logic       RST,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    input  logic [2:0] req_sck,
    input  logic [2:0] req_mosi,
    output logic [2:0] req_miso,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       busy,
    output logic [1:0] owner,
    output logic       timeout_err
);

    if ((GAP_CYCLES < 1) || (GAP_CYCLES > 15)) begin : g_bad_gap
        $error("spi_bus_arbiter: GAP_CYCLES must be 1..15");
    end
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("spi_bus_arbiter: TIMEOUT_CYCLES must be 1..65535");
    end

    // The gap counter is loaded with GAP_CYCLES-1 and exits on zero, so the
    // FSM spends exactly GAP_CYCLES cycles in GAP.
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    logic [1:0] state_r, state_s;
    req_vec_t   gnt_r, gnt_s;
    logic [1:0] owner_r, owner_s;
    logic [1:0] ptr_r, ptr_s;
    logic [3:0] gap_cnt_r, gap_cnt_s;
    logic       busy_r;

    logic       pick_valid_s;
    logic [1:0] pick_idx_s;
    logic       owner_req_s;
    logic       tmo_hit_s;
    req_vec_t   arb_mask_s;

    assign owner_req_s = idx_bit(req, owner_r);

    rr_pick u_rr_pick (
        .req     (req),
        .masked  (arb_mask_s),
        .pointer (ptr_r),
        .valid   (pick_valid_s),
        .index   (pick_idx_s)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_r;
    req_vec_t    lock_r;
    logic        tmo_err_r;
    logic        revoke_s;

    // Counter value TIMEOUT_CYCLES-1 means the grant has been held for
    // TIMEOUT_CYCLES cycles when the current edge arrives.
    assign tmo_hit_s  = (tmo_cnt_r == TMO_LIMIT);
    assign revoke_s   = (state_r == ST_GRANT) && owner_req_s && tmo_hit_s;
    assign arb_mask_s = lock_r;
    assign timeout_err = tmo_err_r;

    // Grant-length counter, lockout of revoked requesters, error pulse.
    always_ff @(posedge CLK50MHZ) begin
        if (!RST) begin
            tmo_cnt_r <= 16'd0;
            lock_r    <= 3'b000;
            tmo_err_r <= 1'b0;
        end else begin
            if ((state_r == ST_GRANT) && (state_s == ST_GRANT)) begin
                tmo_cnt_r <= tmo_cnt_r + 16'd1;
            end else begin
                tmo_cnt_r <= 16'd0;
            end
            // A lock clears as soon as the requester is seen low.
            lock_r    <= (lock_r & req) | (revoke_s ? idx_onehot(owner_r) : 3'b000);
            tmo_err_r <= revoke_s;
        end
    end
`else
    assign tmo_hit_s   = 1'b0;
    assign arb_mask_s  = 3'b000;
    assign timeout_err = 1'b0;
`endif

    // Next-state logic for the IDLE/GRANT/GAP arbiter.
    always_comb begin
        state_s   = state_r;
        gnt_s     = gnt_r;
        owner_s   = owner_r;
        ptr_s     = ptr_r;
        gap_cnt_s = gap_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_s = ST_GRANT;
                    gnt_s   = idx_onehot(pick_idx_s);
                    owner_s = pick_idx_s;
                    ptr_s   = rr_next(pick_idx_s);
                end else begin
                    gnt_s   = 3'b000;
                end
            end
            ST_GRANT: begin
                // Release wins over a timeout falling on the same edge.
                if (!owner_req_s || tmo_hit_s) begin
                    state_s   = ST_GAP;
                    gnt_s     = 3'b000;
                    gap_cnt_s = GAP_LOAD;
                end else begin
                    gnt_s     = gnt_r;
                end
            end
            ST_GAP: begin
                gnt_s = 3'b000;
                if (gap_cnt_r == 4'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = 3'b000;
            end
        endcase
    end

    // Arbiter state registers with synchronous active-low reset.
    always_ff @(posedge CLK50MHZ) begin
        if (!RST) begin
            state_r   <= ST_IDLE;
            gnt_r     <= 3'b000;
            owner_r   <= OWNER_NONE;
            ptr_r     <= REQ_AMP;
            gap_cnt_r <= 4'd0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            gnt_r     <= gnt_s;
            owner_r   <= owner_s;
            ptr_r     <= ptr_s;
            gap_cnt_r <= gap_cnt_s;
            busy_r    <= (state_s != ST_IDLE);
        end
    end

    // Pin steering is combinational from the registered grant so the owner
    // sees its own SCK/MOSI on the pins in the same cycle it drives them.
    assign gnt      = gnt_r;
    assign owner    = owner_r;
    assign busy     = busy_r;
    assign spi_sck  = |(gnt_r & req_sck);
    assign spi_mosi = |(gnt_r & req_mosi);
    assign req_miso = gnt_r & {3{spi_miso}};

endmodule

// File: tb/tb_spi_bus_arbiter.sv
module tb_spi_bus_arbiter;

    localparam int GAP = 2;
    localparam int TMO = 16;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       CLK50MHZ = 1'b0;
    logic       RST = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] req_sck = 3'b000;
    logic [2:0] req_mosi = 3'b000;
    logic       spi_miso = 1'b0;
    logic [2:0] gnt;
    logic [2:0] req_miso;
    logic       spi_sck;
    logic       spi_mosi;
    logic       busy;
    logic [1:0] owner;
    logic       timeout_err;

    spi_bus_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK50MHZ    (CLK50MHZ),
        .RST         (RST),
        .req         (req),
        .gnt         (gnt),
        .req_sck     (req_sck),
        .req_mosi    (req_mosi),
        .req_miso    (req_miso),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .busy        (busy),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    int checks = 0;
    int failures = 0;

    // Reference model: who holds the bus, when the gap ends (absolute edge
    // number), where the rotation resumes, and who is locked out.
    int       m_n = 0;
    int       m_cur = -1;
    int       m_ptr = 0;
    int       m_gap_end = -10;
    int       m_last = 3;
    int       m_start = 0;
    bit [2:0] m_blk = 3'b000;
    bit       m_tmo = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit [2:0] r);
        bit [2:0] blk_old;
        m_n++;
        if (!rst) begin
            m_cur = -1; m_ptr = 0; m_gap_end = -10; m_last = 3;
            m_blk = 3'b000; m_tmo = 1'b0;
            return;
        end
        m_tmo   = 1'b0;
        blk_old = m_blk;
        m_blk   = m_blk & r;
        if (m_cur >= 0) begin
            if (!r[m_cur]) begin
                m_cur = -1;
                m_gap_end = m_n + GAP;
            end else if (TMO_EN && ((m_n - m_start) >= TMO)) begin
                m_blk[m_cur] = 1'b1;
                m_tmo = 1'b1;
                m_cur = -1;
                m_gap_end = m_n + GAP;
            end
        end else if (m_n > m_gap_end) begin
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (m_ptr + k) % 3;
                if (r[i] && !blk_old[i]) begin
                    m_cur = i; m_last = i; m_start = m_n;
                    m_ptr = (i + 1) % 3;
                    break;
                end
            end
        end
    endtask

    task automatic check_model();
        int eg;
        eg = (m_cur >= 0) ? (1 << m_cur) : 0;
        chk("m_gnt", gnt, eg);
        chk("m_owner", owner, m_last);
        chk("m_busy", busy, ((m_cur >= 0) || (m_n < m_gap_end)) ? 1 : 0);
        chk("m_timeout_err", timeout_err, m_tmo);
        chk("m_spi_sck", spi_sck, (m_cur >= 0) ? req_sck[m_cur] : 0);
        chk("m_spi_mosi", spi_mosi, (m_cur >= 0) ? req_mosi[m_cur] : 0);
        chk("m_req_miso", req_miso, spi_miso ? eg : 0);
    endtask

    task automatic step(input bit rst, input bit [2:0] r, input bit [2:0] sck,
                        input bit [2:0] mosi, input bit miso);
        RST = rst; req = r; req_sck = sck; req_mosi = mosi; spi_miso = miso;
        @(posedge CLK50MHZ);
        model_edge(rst, r);
        #1;
        check_model();
    endtask

    typedef struct {
        bit       rst;
        bit [2:0] req;
        bit [2:0] sck;
        bit [2:0] mosi;
        bit       miso;
        bit [2:0] gnt;
        bit [1:0] owner;
        bit       busy;
        bit       osck;
        bit       omosi;
        bit [2:0] omiso;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int n_gr, idle, first_amp, high_cnt, pulses;
        bit regranted;
        bit [2:0] prev, r;
        bit [2:0] order[4];

        // rst  req     sck     mosi    miso  gnt     own   busy  sck   mosi  miso
        tbl[0]  = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 2'd3, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[1]  = '{1'b1, 3'b010, 3'b010, 3'b000, 1'b0, 3'b010, 2'd1, 1'b1, 1'b1, 1'b0, 3'b000};
        tbl[2]  = '{1'b1, 3'b010, 3'b000, 3'b010, 1'b1, 3'b010, 2'd1, 1'b1, 1'b0, 1'b1, 3'b010};
        tbl[3]  = '{1'b1, 3'b011, 3'b001, 3'b001, 1'b1, 3'b010, 2'd1, 1'b1, 1'b0, 1'b0, 3'b010};
        tbl[4]  = '{1'b1, 3'b001, 3'b001, 3'b001, 1'b1, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0, 3'b000};
        tbl[5]  = '{1'b1, 3'b001, 3'b001, 3'b001, 1'b1, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0, 3'b000};
        tbl[6]  = '{1'b1, 3'b001, 3'b001, 3'b001, 1'b1, 3'b000, 2'd1, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[7]  = '{1'b1, 3'b001, 3'b001, 3'b000, 1'b1, 3'b001, 2'd0, 1'b1, 1'b1, 1'b0, 3'b001};
        tbl[8]  = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, 1'b0, 3'b000};
        tbl[9]  = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, 1'b0, 3'b000};
        tbl[10] = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[11] = '{1'b1, 3'b111, 3'b100, 3'b010, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0, 1'b1, 3'b000};
        tbl[12] = '{1'b0, 3'b111, 3'b100, 3'b010, 1'b0, 3'b000, 2'd3, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[13] = '{1'b1, 3'b111, 3'b001, 3'b001, 1'b1, 3'b001, 2'd0, 1'b1, 1'b1, 1'b1, 3'b001};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].sck, tbl[i].mosi, tbl[i].miso);
            chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d_owner", i), owner, tbl[i].owner);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_spi_sck", i), spi_sck, tbl[i].osck);
            chk($sformatf("tbl%0d_spi_mosi", i), spi_mosi, tbl[i].omosi);
            chk($sformatf("tbl%0d_req_miso", i), req_miso, tbl[i].omiso);
        end

        // adc alone for 20 cycles, SCK toggling on all lines.
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 3'b010, 3'($urandom), 3'($urandom), 1'b1);
            chk("adc_only_gnt", gnt, 3'b010);
            chk("adc_only_sck", spi_sck, req_sck[1]);
            chk("adc_only_miso_others", {req_miso[2], req_miso[0]}, 0);
        end
        chk("adc_only_owner", owner, 1);

        // All three requesting; each owner drops after 10 cycles of grant.
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
        order = '{3'b001, 3'b010, 3'b100, 3'b001};
        n_gr = 0; idle = 0; prev = 3'b000;
        for (int c = 0; c < 60; c++) begin
            r = 3'b111;
            if ((m_cur >= 0) && ((m_n + 1 - m_start) >= 10)) r[m_cur] = 1'b0;
            step(1'b1, r, 3'($urandom), 3'($urandom), 1'($urandom));
            if ((gnt != 3'b000) && (prev == 3'b000)) begin
                if (n_gr > 0) chk("rr_idle_gap", idle, GAP + 1);
                if (n_gr < 4) chk($sformatf("rr_order%0d", n_gr), gnt, order[n_gr]);
                n_gr++;
                idle = 0;
            end
            if (gnt == 3'b000) idle++;
            prev = gnt;
        end
        chk("rr_grant_count_ge4", (n_gr >= 4) ? 1 : 0, 1);

        // adc owns, amp raises mid-grant; amp must wait for release + gap.
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'b010, 3'b010, 3'b001, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'b011, 3'b011, 3'b001, 1'b1);
            chk("midgrant_gnt", gnt, 3'b010);
            chk("midgrant_mosi_isolation", spi_mosi, 0);
        end
        first_amp = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 3'b001, 3'b001, 3'b001, 1'b0);
            if ((first_amp < 0) && (gnt == 3'b001)) first_amp = i;
        end
        chk("midgrant_amp_delay", first_amp, GAP + 1);

        // Reset pulse in the middle of a dac grant.
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 3'b100, 3'b100, 3'b100, 1'b1);
        chk("rst_pre_gnt", gnt, 3'b100);
        step(1'b0, 3'b100, 3'b100, 3'b100, 1'b1);
        chk("rst_gnt", gnt, 0);
        chk("rst_sck", spi_sck, 0);
        chk("rst_owner", owner, 3);
        chk("rst_busy", busy, 0);
        step(1'b1, 3'b100, 3'b100, 3'b100, 1'b1);
        chk("rst_regrant", gnt, 3'b100);

        // dac holds req for 40 cycles.
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
        high_cnt = 0; pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 3'b100, 3'($urandom), 3'($urandom), 1'b0);
            if (gnt[2]) high_cnt++;
            if (timeout_err) pulses++;
        end
        chk("tmo_hold_cycles", high_cnt, TMO_EN ? TMO : 40);
        chk("tmo_pulses", pulses, TMO_EN ? 1 : 0);
        step(1'b1, 3'b000, 3'b000, 3'b000, 1'b0);
        regranted = 1'b0;
        for (int i = 0; i < GAP + 1; i++) begin
            step(1'b1, 3'b100, 3'b000, 3'b000, 1'b0);
            if (gnt == 3'b100) regranted = 1'b1;
        end
        chk("tmo_regrant_after_low", regranted, 1);

        // Randomized soak against the model.
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
        r = 3'b000;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            end
            step(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, r,
                 3'($urandom), 3'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
